// File: rtl/trng_uart_word_receiver.sv
// 8N1 UART receiver that reassembles bytes into 32-bit words, MSB byte first,
// with an inter-byte idle timeout that drops partial words to resynchronise.
module trng_uart_word_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        frame_error,
    output logic        timeout
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_reg;
    logic           rx_meta_reg;
    logic           rx_s_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2:0]     bit_reg;
    logic [7:0]     shift_reg;
    logic           armed_reg;
    logic [1:0]     byte_idx_reg;
    logic [31:0]    word_buf_reg;
    logic [TW-1:0]  to_cnt_reg;
    logic [31:0]    word_out_reg;
    logic           word_valid_reg;
    logic           frame_error_reg;
    logic           timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            rx_meta_reg     <= 1'b1;
            rx_s_reg        <= 1'b1;
            cnt_reg         <= '0;
            bit_reg         <= '0;
            shift_reg       <= '0;
            armed_reg       <= 1'b0;
            byte_idx_reg    <= '0;
            word_buf_reg    <= '0;
            to_cnt_reg      <= '0;
            word_out_reg    <= '0;
            word_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            rx_meta_reg     <= rx;
            rx_s_reg        <= rx_meta_reg;
            word_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            timeout_reg     <= 1'b0;

            // Idle-gap timer only runs between bytes of a partially assembled word.
            if (state_reg == IDLE && byte_idx_reg != 2'd0) begin
                if (to_cnt_reg == TO_LAST) begin
                    to_cnt_reg   <= '0;
                    byte_idx_reg <= '0;
                    timeout_reg  <= 1'b1;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (rx_s_reg) begin
                        armed_reg <= 1'b1;
                    end else if (armed_reg) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        if (!rx_s_reg) begin
                            state_reg <= DATA;
                            bit_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s_reg, shift_reg[7:1]};
                        if (bit_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        if (rx_s_reg) begin
                            armed_reg <= 1'b1;
                            // byte_idx wraps 3 -> 0 as the word completes
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            case (byte_idx_reg)
                                2'd0: word_buf_reg[31:24] <= shift_reg;
                                2'd1: word_buf_reg[23:16] <= shift_reg;
                                2'd2: word_buf_reg[15:8]  <= shift_reg;
                                default: begin
                                    word_out_reg   <= {word_buf_reg[31:8], shift_reg};
                                    word_valid_reg <= 1'b1;
                                end
                            endcase
                        end else begin
                            frame_error_reg <= 1'b1;
                            byte_idx_reg    <= '0;
                            armed_reg       <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign word_out    = word_out_reg;
    assign word_valid  = word_valid_reg;
    assign frame_error = frame_error_reg;
    assign timeout     = timeout_reg;
endmodule

// File: tb/tb_trng_uart_word_receiver.sv
// Scoreboard bench: a byte-level model predicts word/frame-error/timeout events,
// a monitor pops and checks them whenever the receiver pulses.
module tb_trng_uart_word_receiver;
    localparam int CPB = 8;
    localparam int TOB = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [31:0] word_out;
    logic        word_valid;
    logic        frame_error;
    logic        timeout;

    always #5 clk = ~clk;

    trng_uart_word_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .word_out(word_out), .word_valid(word_valid),
        .frame_error(frame_error), .timeout(timeout)
    );

    typedef struct {
        int          kind;   // 0 word, 1 frame error, 2 timeout
        logic [31:0] word;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  pending[$];
    logic [31:0] last_word = 32'h0;
    int          errors = 0;
    int          checks = 0;

    function automatic void push_ev(input int kind, input logic [31:0] w);
        ev_t e;
        e.kind = kind;
        e.word = w;
        exp_q.push_back(e);
    endfunction

    // Reference model: collect good bytes into groups of four, drop on bad stop bit.
    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        logic [31:0] w;
        if (!stop_ok) begin
            push_ev(1, 32'h0);
            pending.delete();
        end else begin
            pending.push_back(b);
            if (pending.size() == 4) begin
                w = {pending[0], pending[1], pending[2], pending[3]};
                push_ev(0, w);
                last_word = w;
                pending.delete();
            end
        end
    endfunction

    // Gaps used are either <= 15 or >= 24 bit-times, well clear of the threshold.
    function automatic void model_gap(input int bits);
        if (pending.size() != 0 && bits > TOB) begin
            push_ev(2, 32'h0);
            pending.delete();
        end
    endfunction

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        model_byte(b, stop_ok);
        model_gap(gap);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_ok);
        for (int i = 0; i < gap; i++) hold_bit(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int last_gap);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], 1'b1, (i == 0) ? last_gap : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (word_out !== 32'h0 || word_valid !== 1'b0 || frame_error !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: word_out=%h wv=%b fe=%b to=%b, required all zero",
                     tag, word_out, word_valid, frame_error, timeout);
        end
    endtask

    initial begin
        int drain;
        logic [7:0] rb;
        int gap;
        bit ok;

        fork
            forever begin
                @(negedge clk);
                if (!rst && (word_valid || frame_error || timeout)) begin
                    ev_t e;
                    int act;
                    act = word_valid ? 0 : (frame_error ? 1 : 2);
                    checks++;
                    if ($countones({word_valid, frame_error, timeout}) != 1) begin
                        errors++;
                        $display("FAIL exclusive_pulse: wv=%b fe=%b to=%b, required one-hot",
                                 word_valid, frame_error, timeout);
                    end
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: kind=%0d word_out=%h, required none", act, word_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (act != e.kind) begin
                            errors++;
                            $display("FAIL event_kind: got %0d, required %0d", act, e.kind);
                        end else if (e.kind == 0) begin
                            checks++;
                            if (word_out !== e.word) begin
                                errors++;
                                $display("FAIL word_value: got %h, required %h", word_out, e.word);
                            end else begin
                                $display("word   %h", word_out);
                            end
                        end else begin
                            $display("event  kind=%0d", act);
                        end
                    end
                end
            end
        join_none

        repeat (4) begin
            @(negedge clk);
            check_reset_outputs("power_on_reset");
        end
        @(posedge clk);
        rst = 1'b0;
        repeat (2) hold_bit(1'b1);

        send_word(32'hDEADBEEF, 2);
        send_word(32'h01234567, 0);
        send_word(32'h89ABCDEF, 2);

        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        send_byte(8'h33, 1'b0, 2);
        send_word(32'hAABBCCDD, 2);

        // Short glitch on rx must be rejected at the mid-start check.
        @(posedge clk);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        rx = 1'b1;
        repeat (4) hold_bit(1'b1);

        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 25);
        send_word(32'h01020304, 2);

        // Reset in the middle of bit 4 of the second byte.
        send_byte(8'h11, 1'b1, 0);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(i[0]);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        pending.delete();
        last_word = 32'h0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("mid_byte_reset");
        end
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset_release");
        repeat (2) hold_bit(1'b1);
        send_word(32'hCAFEBABE, 2);

        for (int n = 0; n < 40; n++) begin
            rb  = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 9) != 0);
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(24, 30))
                                              : int'($urandom_range(0, 12));
            if (!ok && gap == 0) gap = 1;
            send_byte(rb, ok, gap);
        end
        model_gap(30);
        repeat (30) hold_bit(1'b1);

        drain = 0;
        while (exp_q.size() != 0 && drain < 2000) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events still outstanding, required 0", exp_q.size());
        end
        checks++;
        if (word_out !== last_word) begin
            errors++;
            $display("FAIL word_held: got %h, required %h", word_out, last_word);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
